// File: rtl/nebula_pkg.sv
// Shared widths and types for the nebula memory endpoint slice.
package nebula_pkg;

  localparam int unsigned CHI_REQ_ADDR_WIDTH   = 48;
  localparam int unsigned CHI_DATA_WIDTH       = 512;
  localparam int unsigned CHI_BE_WIDTH         = CHI_DATA_WIDTH / 8;
  localparam int unsigned MEM_LINE_OFFSET_BITS = 6;
  localparam int unsigned MEM_CNT_WIDTH        = 8;

  // One queued response: payload, error flag and cycles left before it may leave.
  typedef struct packed {
    logic [CHI_DATA_WIDTH-1:0] data;
    logic                      error;
    logic [MEM_CNT_WIDTH-1:0]  countdown;
  } mem_resp_entry_t;

  // Saturating 32-bit increment for statistics counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/nebula_mem_resp_queue.sv
// In-order response FIFO; each entry carries its own latency countdown that
// runs whether or not the entry is at the head.
module nebula_mem_resp_queue #(
  parameter int unsigned DataWidth = 512,
  parameter int unsigned Depth     = 4,
  parameter int unsigned Latency   = 4,
  parameter int unsigned CntW      = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] push_data_i,
  input  logic                 push_err_i,
  input  logic                 pop_i,
  output logic                 head_valid_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 err_o,
  output logic [CntW-1:0]      count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CdW  = (Latency > 1) ? $clog2(Latency) : 1;
  localparam logic [CdW-1:0] CdLoad = CdW'(Latency - 1);

  logic [DataWidth-1:0] data_q [Depth];
  logic                 err_q  [Depth];
  logic [CdW-1:0]       cd_q   [Depth];
  logic [PtrW-1:0]      head_q, tail_q;
  logic [CntW-1:0]      count_q, count_d;
  logic                 head_valid, do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Head may leave only once its countdown has expired.
  always_comb begin
    head_valid = (count_q != '0) && (cd_q[head_q] == '0);
    do_push    = push_i && (count_q != CntW'(Depth));
    do_pop     = pop_i && head_valid;
    count_d    = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy and per-entry countdowns.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) cd_q[i] <= '0;
    end else begin
      if (do_push) tail_q <= next_ptr(tail_q);
      if (do_pop)  head_q <= next_ptr(head_q);
      count_q <= count_d;
      for (int unsigned i = 0; i < Depth; i++) begin
        if (do_push && (tail_q == PtrW'(i))) begin
          cd_q[i] <= CdLoad;
        end else if (cd_q[i] != '0) begin
          cd_q[i] <= cd_q[i] - CdW'(1);
        end
      end
    end
  end

  // Payload storage needs no reset; occupancy gates its visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      data_q[tail_q] <= push_data_i;
      err_q[tail_q]  <= push_err_i;
    end
  end

  assign head_valid_o = head_valid;
  assign data_o       = head_valid ? data_q[head_q] : '0;
  assign err_o        = head_valid & err_q[head_q];
  assign count_o      = count_q;

endmodule

// File: rtl/nebula_mem_endpoint.sv
// Per-node memory endpoint: address decode, byte-enabled line array,
// fixed-latency in-order responses and saturating request statistics.
module nebula_mem_endpoint
  import nebula_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = CHI_REQ_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = CHI_DATA_WIDTH,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned MEM_DEPTH       = 256,
  parameter int unsigned LATENCY         = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req_valid,
  output logic                  mem_req_ready,
  input  logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_write,
  input  logic [DATA_WIDTH-1:0] mem_req_data,
  input  logic [BE_WIDTH-1:0]   mem_req_be,
  output logic                  mem_resp_valid,
  input  logic                  mem_resp_ready,
  output logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  mem_resp_error,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes,
  output logic [31:0]           stat_errors
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  logic [DATA_WIDTH-1:0] line_q [MEM_DEPTH];
  logic [IdxW-1:0]       idx;
  logic [ADDR_WIDTH-1:0] addr_hi;
  logic                  addr_err, accept, resp_pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic [CntW-1:0]       q_count;
  logic [31:0]           stat_reads_q, stat_writes_q, stat_errors_q;

  // Decode the line index and flag misaligned or out-of-range addresses.
  always_comb begin
    idx       = mem_req_addr[MEM_LINE_OFFSET_BITS +: IdxW];
    addr_hi   = mem_req_addr >> (MEM_LINE_OFFSET_BITS + IdxW);
    addr_err  = (mem_req_addr[MEM_LINE_OFFSET_BITS-1:0] != '0) || (addr_hi != '0);
    accept    = mem_req_valid && mem_req_ready;
    push_data = (!mem_req_write && !addr_err) ? line_q[idx] : '0;
    resp_pop  = mem_resp_valid && mem_resp_ready;
  end

  // Ready depends only on registered occupancy; a pop frees space next cycle.
  assign mem_req_ready = (q_count < CntW'(MAX_OUTSTANDING));

  // Byte-enabled line writes at the acceptance edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && mem_req_write && !addr_err) begin
      for (int unsigned b = 0; b < BE_WIDTH; b++) begin
        if (mem_req_be[b]) line_q[idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
      end
    end
  end

  // Saturating counters of accepted reads, writes and errored requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
      stat_errors_q <= '0;
    end else if (accept) begin
      if (addr_err)           stat_errors_q <= sat_inc32(stat_errors_q);
      else if (mem_req_write) stat_writes_q <= sat_inc32(stat_writes_q);
      else                    stat_reads_q  <= sat_inc32(stat_reads_q);
    end
  end

  nebula_mem_resp_queue #(
    .DataWidth (DATA_WIDTH),
    .Depth     (MAX_OUTSTANDING),
    .Latency   (LATENCY),
    .CntW      (CntW)
  ) u_resp_queue (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (accept),
    .push_data_i  (push_data),
    .push_err_i   (addr_err),
    .pop_i        (resp_pop),
    .head_valid_o (mem_resp_valid),
    .data_o       (mem_resp_data),
    .err_o        (mem_resp_error),
    .count_o      (q_count)
  );

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
  assign stat_errors = stat_errors_q;

endmodule

// File: doc/nebula_mem_endpoint.md
Name: nebula_mem_endpoint

Overview:
Per-node memory endpoint that sits directly downstream of the nebula_top memory interface (mem_req_*/mem_resp_*). It consumes line-sized read and write requests and applies byte-enabled writes to a local line array. It returns exactly one in-order response per request after a fixed programmable latency, with a bounded number of outstanding requests. The top-level bench instantiates one per mesh node in place of tied-off memory ports.

Parameters:
ADDR_WIDTH, 48, request address width (matches CHI_REQ_ADDR_WIDTH)
DATA_WIDTH, 512, line width in bits (matches CHI_DATA_WIDTH)
BE_WIDTH, DATA_WIDTH/8, byte-enable width
MEM_DEPTH, 256, number of lines in the local array (power of two)
LATENCY, 4, cycles from request acceptance to earliest resp_valid; legal range is 1 or more
MAX_OUTSTANDING, 4, response queue depth

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_req_valid  in  1  request valid
mem_req_ready  out  1  request accept
mem_req_addr  in  ADDR_WIDTH  byte address
mem_req_write  in  1  1 = write, 0 = read
mem_req_data  in  DATA_WIDTH  write data
mem_req_be  in  BE_WIDTH  byte enables for writes
mem_resp_valid  out  1  response valid
mem_resp_ready  in  1  response accept
mem_resp_data  out  DATA_WIDTH  read data; 0 for writes and errors
mem_resp_error  out  1  address error
stat_reads  out  32  accepted reads, saturating
stat_writes  out  32  accepted writes, saturating
stat_errors  out  32  errored requests, saturating

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values:
  - mem_req_ready = 1; mem_resp_valid = 0; mem_resp_data = 0; mem_resp_error = 0.
  - All stat counters = 0; queue empty.
  - Line array is not reset.
- Accept condition: mem_req_valid && mem_req_ready.
  - mem_req_ready = (count < MAX_OUTSTANDING), from registered count only. There is no same-cycle bypass from a pop.
- Address decode:
  - index = addr[6 +: log2(MEM_DEPTH)].
  - Error if addr[5:0] != 0, or if any addr bit at or above 6+log2(MEM_DEPTH) is set.
- Accepted write, no error: for each byte b with be[b]=1, line[index] byte b = data byte b, applied at the acceptance edge. Response data = 0, error = 0.
- Accepted read, no error: line[index] is sampled in the acceptance cycle and reflects all previously accepted writes. Response carries that data, error = 0.
- Error request: no array access. Response data = 0, error = 1. stat_errors increments; stat_reads/stat_writes do not.
- Queue:
  - In-order FIFO of {data, error, countdown}. Countdown loads LATENCY-1 on push.
  - Every non-zero countdown decrements each cycle, including entries behind the head.
- Response output:
  - mem_resp_valid = queue non-empty && head countdown == 0.
  - Accept at edge T gives earliest resp_valid in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles later.
  - While resp_valid && !resp_ready, data and error are held stable.
- Pop on resp_valid && resp_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Full queue plus a pop: ready rises the next cycle.
- Back-to-back accepted requests produce back-to-back responses when resp_ready = 1.
- Stat counters saturate at 32'hFFFFFFFF.
- Reset asserted mid-operation: the queue is flushed; the in-flight response is dropped, not completed. Array contents are retained.

Decomposition:
- nebula_pkg:
  - Reuse CHI_REQ_ADDR_WIDTH / CHI_DATA_WIDTH / CHI_BE_WIDTH.
  - Add MEM_LINE_OFFSET_BITS = 6.
  - Add typedef mem_resp_entry_t {data, error, countdown}.
- One sub-module, nebula_mem_resp_queue: parameterised FIFO with per-entry countdown, head-ready output and count output.
- The top holds the decode, line array and stats.

Test Plan:
- Write addr 0x40, data all 0xA5 bytes, be all ones; then read 0x40 with resp_ready=1 -> two responses, each LATENCY=4 cycles after its accept; write resp data 0, error 0; read data all 0xA5.
- Write addr 0x80, data 0x11.., be = 64'h0F; then read 0x80 -> bytes 0-3 = 0x11, bytes 4-63 equal the prior contents from the initial full-line write of 0x00.
- Hold resp_ready=0 and issue 5 reads -> 4 accepted, ready=0 on the 5th, stat_reads=4. Release resp_ready -> 4 in-order responses with stable data while stalled; 5th accepted the cycle after the first pop.
- Read addr 0x41 (unaligned) and addr 0x4000 (index out of range) -> error=1, data=0, stat_errors=2, stat_reads unchanged.
- Assert rst for 1 cycle with 3 responses queued -> resp_valid=0 and ready=1 the cycle after. A subsequent read of a prior written line returns the old contents.
- LATENCY=1 build: 8 back-to-back reads with resp_ready=1 -> resp_valid high for 8 consecutive cycles, starting 1 cycle after the first accept.
